// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, idle line level and counter sizing for the serial transmitter.
package piso_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;
  typedef enum logic {IDLE = ST_IDLE, SHIFT = ST_SHIFT} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: modulo-DIV period counter with a registered tick on the last count.
module bit_tick_gen import piso_pkg::*; #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = cnt_w(DIV);
  logic [CW-1:0] cnt, cnt_nxt;
  logic active;
  // run describes the coming cycle, so a fresh run always begins at count 0
  assign cnt_nxt = (active && cnt != CW'(DIV - 1)) ? cnt + CW'(1) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tick <= 1'b0;
      active <= 1'b0;
    end else begin
      cnt <= run ? cnt_nxt : '0;
      tick <= run && cnt_nxt == CW'(DIV - 1);
      active <= run;
    end
  end
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter driving a d/enable pair, one bit per DIV clocks.
module piso_tx import piso_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIV = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             enable_out,
  output logic             busy,
  output logic             done
);
  localparam int BW = cnt_w(WIDTH);
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic tick, accept, last, run;
  assign accept = ready_out && valid_in;
  assign last = state == SHIFT && tick && bit_cnt == BW'(WIDTH - 1);
  assign run = accept || (state == SHIFT && !last);
  assign sreg_nxt = MSB_FIRST ? sreg << 1 : sreg >> 1;
  assign enable_out = tick;
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      sreg <= '0;
      ready_out <= 1'b1;
      d_out <= IDLE_LEVEL;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      bit_cnt <= '0;
      sreg <= data_in;
      ready_out <= 1'b0;
      d_out <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == SHIFT && tick) begin
      if (last) begin
        state <= IDLE;
        ready_out <= 1'b1;
        d_out <= IDLE_LEVEL;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
        sreg <= sreg_nxt;
        d_out <= MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed vector table plus loopback and async-reset sequences for piso_tx.
module tb_piso_tx;
  logic clk, rst_n;
  logic [7:0] din [3];
  logic [2:0] vin, rdy, dq, en, bsy, dn;
  logic [7:0] rx;
  int nvec, nbad;

  typedef struct {
    int sel;
    logic [7:0] data;
    logic [7:0] seq;
    int div;
    bit noise;
  } vec_t;
  vec_t tbl [5];

  piso_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .valid_in(vin[0]), .ready_out(rdy[0]),
    .d_out(dq[0]), .enable_out(en[0]), .busy(bsy[0]), .done(dn[0]));
  piso_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .valid_in(vin[1]), .ready_out(rdy[1]),
    .d_out(dq[1]), .enable_out(en[1]), .busy(bsy[1]), .done(dn[1]));
  piso_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .valid_in(vin[2]), .ready_out(rdy[2]),
    .d_out(dq[2]), .enable_out(en[2]), .busy(bsy[2]), .done(dn[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // receiver: d_ff sampled on enable feeding an 8-bit shift register
  always @(posedge clk) if (en[0]) rx <= {rx[6:0], dq[0]};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs(input int sel);
    return {dq[sel], en[sel], bsy[sel], rdy[sel], dn[sel]};
  endfunction

  task automatic run_frame(input int sel, input logic [7:0] data, input logic [7:0] seq,
                           input int div, input bit noise);
    logic e;
    @(negedge clk);
    din[sel] = data;
    vin[sel] = 1'b1;
    @(posedge clk);
    #1 vin[sel] = 1'b0;
    for (int c = 0; c < 8 * div; c++) begin
      if (noise && c == 5) begin
        din[sel] = 8'h00;
        vin[sel] = 1'b1;
      end
      e = (c % div) == (div - 1);
      chk($sformatf("frame%0d %h c%0d {d,en,busy,rdy,done}", sel, data, c), 8'(outs(sel)),
          8'({seq[7 - c / div], e, 3'b100}));
      @(posedge clk);
      #1;
    end
    vin[sel] = 1'b0;
    chk($sformatf("frame%0d %h done cycle", sel, data), 8'(outs(sel)), 8'b00011);
    @(posedge clk);
    #1 chk($sformatf("frame%0d %h idle after", sel, data), 8'(outs(sel)), 8'b00010);
  endtask

  task automatic wait_done(input int sel, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!dn[sel] && n < 200);
  endtask

  initial begin
    int n;
    nvec = 0;
    nbad = 0;
    tbl[0] = '{0, 8'hA5, 8'hA5, 4, 1'b0};
    tbl[1] = '{1, 8'hA5, 8'hA5, 4, 1'b0};
    tbl[2] = '{1, 8'h01, 8'h80, 4, 1'b0};
    tbl[3] = '{2, 8'hF0, 8'hF0, 1, 1'b0};
    tbl[4] = '{0, 8'hAA, 8'hAA, 4, 1'b1};
    rst_n = 1'b0;
    vin = '0;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    #12;
    for (int i = 0; i < 3; i++) chk($sformatf("reset outs%0d", i), 8'(outs(i)), 8'b00010);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_frame(tbl[i].sel, tbl[i].data, tbl[i].seq, tbl[i].div, tbl[i].noise);

    // back-to-back frames with valid held high, checked through the receiver
    @(negedge clk);
    din[0] = 8'h3C;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 din[0] = 8'hC3;
    wait_done(0, n);
    chk("loop frame1 length", 8'(n), 8'd32);
    chk("loop rx 3C", rx, 8'h3C);
    chk("loop idle gap", 8'(outs(0)), 8'b00011);
    @(posedge clk);
    #1 chk("loop reaccept {busy,rdy}", 8'({bsy[0], rdy[0]}), 8'b10);
    vin[0] = 1'b0;
    wait_done(0, n);
    chk("loop frame2 length", 8'(n), 8'd32);
    chk("loop rx C3", rx, 8'hC3);
    @(posedge clk);
    #1 chk("loop idle after", 8'(outs(0)), 8'b00010);

    // asynchronous reset during bit 3 of 8'hFF
    @(negedge clk);
    din[0] = 8'hFF;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 vin[0] = 1'b0;
    repeat (13) @(posedge clk);
    #1 chk("pre-reset busy bit3", 8'(outs(0)), 8'b10100);
    #2 rst_n = 1'b0;
    #1 chk("async reset outs", 8'(outs(0)), 8'b00010);
    @(posedge clk);
    #1 chk("held reset no done", 8'(outs(0)), 8'b00010);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'h81, 8'h81, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It drives the d/enable pair that a d_ff-based serial receiver samples.
- It accepts a WIDTH-bit word through a valid/ready handshake.
- It then emits the word one bit at a time on d_out. Each bit is held for DIV clocks.
- enable_out is strobed once per bit, so a downstream d_ff captures each bit while d is stable.

Parameters:
- WIDTH, 8: bits per word; legal range is 2 or more.
- DIV, 4: clocks per bit period; legal range is 1 or more.
- MSB_FIRST, 1: 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to send; sampled only at accept.
- valid_in  input  1  the word on data_in is valid.
- ready_out  output  1  the block can accept a word.
- d_out  output  1  serial data bit.
- enable_out  output  1  sample strobe for the receiver's enable input.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; counters = 0; shift register = 0.
  - ready_out = 1; d_out = 0; enable_out = 0; busy = 0; done = 0.
- Reset mid-frame aborts the frame immediately. No done pulse is produced, and the partial word is discarded.
- States: IDLE and SHIFT.
- IDLE:
  - ready_out = 1; d_out = 0; enable_out = 0.
  - Accept occurs on a rising edge with valid_in = 1 and ready_out = 1.
  - After the accept edge: state = SHIFT, ready_out = 0, busy = 1, div_cnt = 0, bit_cnt = 0.
  - The shift register loads data_in, and d_out = the first bit (selected by MSB_FIRST).
- SHIFT:
  - div_cnt counts 0..DIV-1 within each bit period.
  - d_out is constant for the whole bit period.
  - enable_out = 1 exactly during the cycle where div_cnt = DIV-1 (the last cycle of the period). It is 0 otherwise.
  - On the edge ending a period with bit_cnt < WIDTH-1: bit_cnt increments, the shift register advances, and d_out = the next bit.
  - On the edge ending the period with bit_cnt = WIDTH-1: state = IDLE, done = 1 for one cycle, ready_out = 1, busy = 0, d_out = 0.
- Frame length:
  - SHIFT lasts exactly WIDTH*DIV cycles.
  - done is high in cycle WIDTH*DIV after the accept edge.
  - Exactly WIDTH enable_out pulses occur per frame.
- Back-to-back frames:
  - A new accept may occur on the edge that ends the done cycle.
  - Between frames there is therefore exactly one IDLE cycle, with d_out = 0 and enable_out = 0.
- DIV = 1: enable_out is high for every SHIFT cycle, and d_out changes every cycle.
- valid_in while busy is ignored. Changes on data_in after accept do not affect the frame in flight.
- Counter widths: $clog2(DIV) for div_cnt and $clog2(WIDTH) for bit_cnt, each with a minimum of 1 bit. No wrap beyond the terminal counts.

Decomposition:
- Package piso_pkg contains:
  - state encoding localparams: ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - IDLE_LEVEL = 1'b0.
- Sub-module bit_tick_gen (parameter DIV), with ports clk, rst_n, run, tick.
  - It is a modulo-DIV counter cleared while run = 0.
  - tick is high on count DIV-1.
  - piso_tx uses tick for enable_out and for bit advance.

Test Plan:
1. WIDTH=8, DIV=4, MSB_FIRST=1; accept 8'hA5.
   - d_out = 1,0,1,0,0,1,0,1, each bit held 4 cycles.
   - enable_out pulses in cycles 3, 7, …, 31 after accept.
   - done is high in cycle 32; ready_out returns to 1 in the same cycle.
2. Same configuration with MSB_FIRST=0; accept 8'hA5.
   - d_out = 1,0,1,0,0,1,0,1 (LSB first; the pattern is palindromic).
   - Repeat with 8'h01 and check d_out = 1,0,0,0,0,0,0,0.
3. Loopback: connect d_out and enable_out into d_ff plus an 8-bit shift register; send 8'h3C then 8'hC3 with valid_in held high.
   - The receiver reconstructs 8'h3C and then 8'hC3.
   - Exactly one IDLE cycle occurs between frames.
4. DIV=1; accept 8'hF0.
   - enable_out is high for 8 consecutive cycles, with d_out = 1,1,1,1,0,0,0,0.
   - done is high in cycle 8.
5. Deassert rst_n asynchronously (mid-clock) during bit 3 of 8'hFF.
   - Outputs immediately return to reset values, with no done pulse.
   - After release, a fresh accept of 8'h81 transmits correctly.
6. During a frame, drive valid_in = 1 with data_in = 8'h00 while sending 8'hAA.
   - The frame still emits 8'hAA.
   - No second accept occurs until ready_out = 1.
